fifo_hs: RTL
============

FIFO_HS -- requirements
Module: fifo_hs

Interface
REQ-001 SHALL have parameter WIDTH, 32, data bits per entry (>=1).
REQ-002 SHALL have parameter DEPTH, 16, entry count (power of 2, >=2).
REQ-003 SHALL have parameter AF_TH, DEPTH-2, almost-full threshold; used only when FIFO_HS_ALMOST_FLAGS_EN is defined.
REQ-004 SHALL have parameter AE_TH, 2, almost-empty threshold; used only when FIFO_HS_ALMOST_FLAGS_EN is defined.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have push ports: push_req in 1; push_ack out 1; push_ack_pulse out 1; push_data in WIDTH; push_stream_mode in 1; fifo_full out 1.
REQ-008 SHALL have pop ports: pop_req in 1; pop_ack out 1; pop_ack_pulse out 1; pop_data out WIDTH; pop_stream_mode in 1; fifo_empty out 1.
REQ-009 SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-010 SHALL have ports almost_full and almost_empty, output, 1 bit each, only when FIFO_HS_ALMOST_FLAGS_EN is defined.

Function
REQ-011 SHALL implement a circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits, the MSB being the wrap bit.
REQ-012 SHALL drive fifo_full = (count==DEPTH) and fifo_empty = (count==0), both registered-state derived.
REQ-013 SHALL run one FSM per side with states IDLE and HOLD; each side latches its stream_mode only in IDLE while its req is low.
REQ-014 Push 4-phase: in IDLE with push_req=1 and !fifo_full, the FSM writes push_data at that edge, enters HOLD, and push_ack rises on the following cycle.
REQ-015 Push 4-phase: in HOLD, push_ack stays 1 until push_req is sampled 0; push_ack then falls the next cycle and the FSM returns to IDLE. No further write occurs in HOLD.
REQ-016 Push stream: push_ack = push_req & !fifo_full (combinational); a write occurs on every edge where push_ack=1.
REQ-017 Pop 4-phase: in IDLE with pop_req=1 and !fifo_empty, the FSM captures the head into a pop_data register, advances rd at that edge, and enters HOLD; pop_ack rises on the following cycle.
REQ-018 Pop 4-phase: pop_data and pop_ack hold stable until pop_req is sampled 0; pop_ack then falls the next cycle and the FSM returns to IDLE.
REQ-019 Pop stream: pop_ack = pop_req & !fifo_empty; pop_data = head entry (show-ahead, combinational); rd advances on each edge where pop_ack=1.
REQ-020 push_ack_pulse SHALL be high exactly one cycle per accepted write (the first ack cycle in 4-phase; equal to push_ack in stream); pop_ack_pulse likewise for reads.
REQ-021 A push and a pop on the same edge SHALL both complete, leaving count unchanged.
REQ-022 When full, a push SHALL stall even if a pop occurs on the same edge (no bypass); when empty, a pop SHALL stall even if a push occurs on the same edge (no fall-through).
REQ-023 Pointer wrap from DEPTH-1 to 0 SHALL toggle the wrap bit with no data loss.

Reset
REQ-024 While rst=1 at an edge: pointers=0, count=0, both FSMs in IDLE, push_ack=pop_ack=0, both pulses=0, pop_data register=0, fifo_empty=1, fifo_full=0.
REQ-025 Reset asserted mid-handshake SHALL abort that handshake; acks drop at the next edge, and an entry written at that edge is discarded.
REQ-026 Memory contents SHALL NOT require reset.

Configuration
REQ-027 With FIFO_HS_ALMOST_FLAGS_EN defined: almost_full = (count>=AF_TH) and almost_empty = (count<=AE_TH), both registered and reset to 0 and 1 respectively.
REQ-028 Without FIFO_HS_ALMOST_FLAGS_EN: the almost_full/almost_empty ports, the threshold logic, and the AF_TH/AE_TH usage SHALL be absent.

Verification
REQ-029 DEPTH=4, 4-phase push of 0xA,0xB -> push_ack high 1 cycle after each req rise, one push_ack_pulse each, count=2.
REQ-030 Stream push of 5 words into DEPTH=4 with pop_req=0 -> 4 acks, push_ack=0 on the 5th, fifo_full=1, count=4.
REQ-031 Stream pop from full 0x1..0x4 -> pop_data 0x1,0x2,0x3,0x4 on consecutive ack cycles, then fifo_empty=1 and pop_ack=0.
REQ-032 Full FIFO with stream push and stream pop on the same cycle -> pop accepted, push stalls one cycle, count 4->3->4.
REQ-033 rst pulsed while 4-phase push is in HOLD -> push_ack=0 next edge, count=0; a new handshake after reset completes normally.
REQ-034 With FIFO_HS_ALMOST_FLAGS_EN, DEPTH=16, AF_TH=14: the 14th write sets almost_full=1 and one pop clears it.

Source files
------------

// File: rtl/fifo_hs.sv
// fifo_hs: single-clock circular-buffer FIFO with independent handshakes on
// the push and pop sides. Each side runs either a 4-phase req/ack handshake
// (one transfer per req pulse) or a streaming valid/ready-style handshake
// (one transfer per cycle while req is high and space/data is available).
//
// Optional feature: define FIFO_HS_ALMOST_FLAGS_EN to add the registered
// almost_full / almost_empty outputs and the AF_TH / AE_TH thresholds.
module fifo_hs #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
`ifdef FIFO_HS_ALMOST_FLAGS_EN
  ,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  // push side
  input  logic                       push_req,
  output logic                       push_ack,
  output logic                       push_ack_pulse,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       push_stream_mode,
  output logic                       fifo_full,
  // pop side
  input  logic                       pop_req,
  output logic                       pop_ack,
  output logic                       pop_ack_pulse,
  output logic [WIDTH-1:0]           pop_data,
  input  logic                       pop_stream_mode,
  output logic                       fifo_empty,
  // occupancy
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FIFO_HS_ALMOST_FLAGS_EN
  ,
  output logic                       almost_full,
  output logic                       almost_empty
`endif
);

  // AW indexes the storage; pointers carry one extra wrap bit so that
  // full and empty are distinguishable when the indices are equal.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hs_state_e;

  // storage (no reset needed: a slot is only read after being written)
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] head_data;

  hs_state_e        push_state_reg;
  hs_state_e        push_state_next;
  hs_state_e        pop_state_reg;
  hs_state_e        pop_state_next;

  // handshake flavour per side: 1 = streaming, 0 = 4-phase
  logic             push_mode_reg;
  logic             pop_mode_reg;

  // high during the first ack cycle of a 4-phase transfer
  logic             push_first_reg;
  logic             pop_first_reg;

  logic [WIDTH-1:0] pop_data_reg;

  // a transfer actually happens at the coming edge
  logic             push_fire;
  logic             pop_fire;

  assign wr_idx    = wr_ptr_reg[AW-1:0];
  assign rd_idx    = rd_ptr_reg[AW-1:0];
  assign head_data = mem[rd_idx];

  // Occupancy comes straight from the registered pointers; the wrap bit
  // makes the modulo-2*DEPTH difference equal to the true entry count.
  assign count      = CW'(wr_ptr_reg - rd_ptr_reg);
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

  // ---------------------------------------------------------------------
  // Push side
  // ---------------------------------------------------------------------

  // Push FSM state register, mode latch and first-ack flag.
  // The mode is only sampled while idle with req low so a transfer in
  // flight can never change flavour underneath itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_state_reg <= ST_IDLE;
      push_mode_reg  <= 1'b0;
      push_first_reg <= 1'b0;
    end else begin
      push_state_reg <= push_state_next;
      if (push_state_reg == ST_IDLE && !push_req) begin
        push_mode_reg <= push_stream_mode;
      end
      push_first_reg <= push_fire && !push_mode_reg;
    end
  end

  // Push next-state: a write only starts from IDLE with space available;
  // fullness is taken from registered state, so a same-edge pop never
  // frees a slot early.
  always_comb begin
    push_state_next = push_state_reg;
    push_fire       = 1'b0;
    case (push_state_reg)
      ST_IDLE: begin
        if (push_req && !fifo_full) begin
          push_fire = 1'b1;
          if (!push_mode_reg) begin
            push_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!push_req) begin
          push_state_next = ST_IDLE;
        end
      end
      default: push_state_next = ST_IDLE;
    endcase
  end

  // Push outputs: streaming ack is combinational, 4-phase ack is the HOLD state.
  always_comb begin
    push_ack       = 1'b0;
    push_ack_pulse = 1'b0;
    if (push_mode_reg) begin
      push_ack       = push_req && !fifo_full;
      push_ack_pulse = push_req && !fifo_full;
    end else begin
      push_ack       = (push_state_reg == ST_HOLD);
      push_ack_pulse = push_first_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Pop side
  // ---------------------------------------------------------------------

  // Pop FSM state register, mode latch, first-ack flag and captured data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_state_reg <= ST_IDLE;
      pop_mode_reg  <= 1'b0;
      pop_first_reg <= 1'b0;
      pop_data_reg  <= '0;
    end else begin
      pop_state_reg <= pop_state_next;
      if (pop_state_reg == ST_IDLE && !pop_req) begin
        pop_mode_reg <= pop_stream_mode;
      end
      pop_first_reg <= pop_fire && !pop_mode_reg;
      if (pop_fire && !pop_mode_reg) begin
        pop_data_reg <= head_data;
      end
    end
  end

  // Pop next-state: a read only starts from IDLE with data present;
  // emptiness is registered, so a same-edge push never falls through.
  always_comb begin
    pop_state_next = pop_state_reg;
    pop_fire       = 1'b0;
    case (pop_state_reg)
      ST_IDLE: begin
        if (pop_req && !fifo_empty) begin
          pop_fire = 1'b1;
          if (!pop_mode_reg) begin
            pop_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!pop_req) begin
          pop_state_next = ST_IDLE;
        end
      end
      default: pop_state_next = ST_IDLE;
    endcase
  end

  // Pop outputs: streaming shows the head entry directly (show-ahead);
  // 4-phase presents the value captured when the read was taken.
  always_comb begin
    pop_ack       = 1'b0;
    pop_ack_pulse = 1'b0;
    pop_data      = pop_data_reg;
    if (pop_mode_reg) begin
      pop_ack       = pop_req && !fifo_empty;
      pop_ack_pulse = pop_req && !fifo_empty;
      pop_data      = head_data;
    end else begin
      pop_ack       = (pop_state_reg == ST_HOLD);
      pop_ack_pulse = pop_first_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Storage and pointers
  // ---------------------------------------------------------------------

  // Memory write; gated by rst so a write racing a reset edge leaves no trace.
  always_ff @(posedge clk) begin
    if (push_fire && !rst) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Pointer update; the wrap bit toggles naturally on DEPTH-1 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_fire) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (pop_fire) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

`ifdef FIFO_HS_ALMOST_FLAGS_EN
  // ---------------------------------------------------------------------
  // Almost flags
  // ---------------------------------------------------------------------
  logic [CW-1:0] count_next;
  logic          almost_full_reg;
  logic          almost_empty_reg;

  // Occupancy after the coming edge, so the registered flags line up
  // with the count output in the same cycle.
  always_comb begin
    count_next = count + CW'(push_fire) - CW'(pop_fire);
  end

  // Threshold flags, registered from the next-cycle occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      almost_full_reg  <= (int'(count_next) >= AF_TH);
      almost_empty_reg <= (int'(count_next) <= AE_TH);
    end
  end

  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
`endif

endmodule
